// File: rtl/serial_add_seq_pkg.sv
// Shared state encodings and op codes for the bit-serial add/subtract sequencer.
package serial_add_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared by the serial datapath.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract sequencer: one full_adder reused for WIDTH cycles, LSB first.
// Define SERIAL_SUB_EN to enable subtraction (op = 1 computes a + ~b + 1).
module serial_add_seq
   import serial_add_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             ack,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   state_t             state;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic               carry;
   logic [CNT_W-1:0]   cnt;
   logic               fa_b;
   logic               fa_s;
   logic               fa_cout;
   logic [WIDTH-1:0]   res_next;
   logic               last_bit;

`ifdef SERIAL_SUB_EN
   logic sub_q;
   assign fa_b = op_b[0] ^ sub_q;
`else
   logic unused_op;
   assign unused_op = op;
   assign fa_b      = op_b[0];
`endif

   full_adder u_fa (
      .a    (op_a[0]),
      .b    (fa_b),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_cout)
   );

   assign res_next = {fa_s, result[WIDTH-1:1]};
   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   // Sequencer: owns operands, carry, counter, result and flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         op_a   <= '0;
         op_b   <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
         zero   <= 1'b0;
`ifdef SERIAL_SUB_EN
         sub_q  <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_a  <= a;
                  op_b  <= b;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= ST_RUN;
`ifdef SERIAL_SUB_EN
                  sub_q <= (op == OP_SUB);
                  carry <= (op == OP_SUB) ? 1'b1 : cin;
`else
                  carry <= cin;
`endif
               end
            end
            ST_RUN: begin
               op_a   <= op_a >> 1;
               op_b   <= op_b >> 1;
               result <= res_next;
               carry  <= fa_cout;
               if (last_bit) begin
                  // Carry into the MSB is the registered carry feeding this final bit.
                  cout  <= fa_cout;
                  ovf   <= carry ^ fa_cout;
                  zero  <= (res_next == '0);
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_DONE: begin
               if (ack) begin
                  done  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed, table-driven bench for serial_add_seq at WIDTH = 8 (honours SERIAL_SUB_EN).
module tb_serial_add_seq;

   localparam int unsigned W = 8;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         op;
      logic [W-1:0] res;
      logic         co;
      logic         ov;
      logic         z;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst, start, op, cin, ack;
   logic [W-1:0] a, b, result;
   logic         busy, done, cout, ovf, zero;

   int errors = 0;
   int checks = 0;
   vec_t vecs [9];

   serial_add_seq #(.WIDTH(W), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
      .ack(ack), .busy(busy), .done(done), .result(result), .cout(cout),
      .ovf(ovf), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vcin, input logic vop);
      a = va; b = vb; cin = vcin; op = vop; start = 1'b1;
      tick();
      start = 1'b0;
      // Scramble inputs to prove they were latched at the accepting edge.
      a = ~va; b = ~vb; cin = ~vcin; op = ~vop;
   endtask

   task automatic wait_done(input string tag);
      int lat = 0;
      int busy_n = 0;
      while (!done && lat < 40) begin
         if (busy) busy_n++;
         tick();
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'd8);
      chk({tag, " busy cycles"}, 32'(busy_n), 32'd8);
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, " busy"}, 32'(busy), 32'd0);
      chk({tag, " done"}, 32'(done), 32'd0);
      chk({tag, " result"}, 32'(result), 32'd0);
      chk({tag, " cout"}, 32'(cout), 32'd0);
      chk({tag, " ovf"}, 32'(ovf), 32'd0);
      chk({tag, " zero"}, 32'(zero), 32'd0);
   endtask

   initial begin
      int n;
      logic held_ok;

      vecs[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
      vecs[5] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
`ifdef SERIAL_SUB_EN
      vecs[6] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
      vecs[8] = '{8'h55, 8'h55, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
`else
      vecs[6] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{8'h55, 8'h55, 1'b1, 1'b1, 8'hAB, 1'b0, 1'b1, 1'b0};
`endif

      rst = 1'b1; start = 1'b0; op = 1'b0; cin = 1'b0; ack = 1'b0; a = '0; b = '0;
      tick(); tick();
      check_zero_outputs("reset");
      rst = 1'b0;
      tick();

      for (int i = 0; i < 9; i++) begin
         launch(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op);
         wait_done($sformatf("vec%0d", i));
         chk($sformatf("vec%0d result", i), 32'(result), 32'(vecs[i].res));
         chk($sformatf("vec%0d cout", i), 32'(cout), 32'(vecs[i].co));
         chk($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].ov));
         chk($sformatf("vec%0d zero", i), 32'(zero), 32'(vecs[i].z));
         ack = 1'b1;
         tick();
         ack = 1'b0;
         chk($sformatf("vec%0d done after ack", i), 32'(done), 32'd0);
      end

      // Handshake: start and ack during RUN are ignored.
      launch(8'h01, 8'h01, 1'b0, 1'b0);
      tick();
      a = 8'hFF; b = 8'hFF; start = 1'b1; ack = 1'b1;
      tick();
      start = 1'b0; ack = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      chk("hs done reached", 32'(done), 32'd1);
      chk("hs result", 32'(result), 32'h02);

      // Hold DONE 20 cycles with ack low while start pulses.
      held_ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         start = i[0];
         a = 8'h10;
         tick();
         if (done !== 1'b1 || result !== 8'h02 || busy !== 1'b0) held_ok = 1'b0;
      end
      start = 1'b0;
      chk("hs held in done", 32'(held_ok), 32'd1);

      // start together with ack in DONE: only ack acts.
      start = 1'b1; ack = 1'b1;
      tick();
      start = 1'b0; ack = 1'b0;
      chk("hs ack done", 32'(done), 32'd0);
      chk("hs ack busy", 32'(busy), 32'd0);
      tick(); tick();
      chk("hs start not queued", 32'(busy), 32'd0);

      launch(8'h01, 8'h01, 1'b0, 1'b0);
      wait_done("hs restart");
      chk("hs restart result", 32'(result), 32'h02);
      ack = 1'b1;
      tick();
      ack = 1'b0;

      // Reset in the middle of RUN.
      launch(8'h5A, 8'h3C, 1'b0, 1'b0);
      tick(); tick(); tick();
      chk("rst mid busy before", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_zero_outputs("rst mid");
      tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();
      chk("rst mid stays idle", 32'(done | busy), 32'd0);

      launch(8'h5A, 8'h3C, 1'b0, 1'b0);
      wait_done("post rst");
      chk("post rst result", 32'(result), 32'h96);
      chk("post rst cout", 32'(cout), 32'd0);
      chk("post rst ovf", 32'(ovf), 32'd1);
      chk("post rst zero", 32'(zero), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
